// File: rtl/cvita_pkt_gen.sv
// cvita_pkt_gen: CHDR/CVITA burst packet source on a 64-bit AXI-Stream master.
// Define CVITA_PKT_GEN_LFSR_EN to make payload mode 1 a 64-bit Galois LFSR.
module cvita_pkt_gen #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_pkt_type,
  input  logic             cfg_has_time,
  input  logic             cfg_eob_last,
  input  logic [31:0]      cfg_sid,
  input  logic [11:0]      cfg_seq_start,
  input  logic [15:0]      cfg_num_samps,
  input  logic [CNT_W-1:0] cfg_num_pkts,
  input  logic [1:0]       cfg_mode,
  input  logic [63:0]      cfg_ramp_start,
  input  logic [63:0]      cfg_ramp_inc,
  input  logic [63:0]      cfg_timestamp,
  input  logic [63:0]      cfg_ts_inc,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic [63:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_count
);
  typedef enum logic [2:0] {IDLE, HDR, TIME, DATA, GAP, DONE} state_t;
  state_t state_q, state_d, after_pkt;
  logic [1:0] type_q, mode_q;
  logic has_time_q, eob_last_q, abort_q;
  logic [31:0] sid_q;
  logic [11:0] seq_q;
  logic [15:0] num_samps_q, samp_cnt_q, len;
  logic [CNT_W-1:0] num_pkts_q, cnt_q;
  logic [63:0] ramp_start_q, ramp_inc_q, ts_q, ts_inc_q, word_q, payload, hdr;
  logic [GAP_W-1:0] gap_q, gap_cnt_q;
  logic accept, hs, last_word, end_pkt, final_pkt, stop, in_pkt;

  assign accept    = start && state_q == IDLE;
  assign in_pkt    = state_q == HDR || state_q == TIME || state_q == DATA;
  assign hs        = o_tvalid && o_tready;
  assign last_word = state_q == DATA ? samp_cnt_q == num_samps_q - 16'd1
                   : num_samps_q == 16'd0 && (state_q == TIME || (state_q == HDR && !has_time_q));
  assign end_pkt   = hs && last_word;
  assign final_pkt = num_pkts_q != '0 && cnt_q == num_pkts_q - CNT_W'(1);
  assign stop      = final_pkt || abort_q || abort;
  assign after_pkt = stop ? DONE : gap_q != '0 ? GAP : HDR;
  assign len       = {num_samps_q[12:0], 3'b000} + (has_time_q ? 16'd16 : 16'd8);
  assign hdr       = {type_q, has_time_q, eob_last_q && final_pkt, seq_q, len, sid_q};
  assign pkt_count = cnt_q;

`ifdef CVITA_PKT_GEN_LFSR_EN
  logic [63:0] lfsr_q;
  assign payload = mode_q == 2'd2 ? ramp_start_q : mode_q == 2'd1 ? lfsr_q : word_q;
  // Right-shifting Galois form; mask holds taps 63,61,60 plus the x^64 feedback.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lfsr_q <= '0;
    else if (accept) lfsr_q <= cfg_ramp_start == '0 ? 64'd1 : cfg_ramp_start;
    else if (hs && state_q == DATA)
      lfsr_q <= {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? 64'hD800_0000_0000_0000 : 64'd0);
`else
  assign payload = mode_q == 2'd2 ? ramp_start_q : word_q;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? HDR : IDLE;
      HDR:  if (hs) state_d = last_word ? after_pkt : has_time_q ? TIME : DATA;
      TIME: if (hs) state_d = last_word ? after_pkt : DATA;
      DATA: if (end_pkt) state_d = after_pkt;
      GAP:  state_d = abort ? DONE : gap_cnt_q == gap_q - GAP_W'(1) ? HDR : GAP;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = in_pkt;
    o_tlast  = last_word;
    o_tdata  = state_q == HDR ? hdr : state_q == TIME ? ts_q : state_q == DATA ? payload : 64'd0;
    busy     = in_pkt || state_q == GAP;
    done     = state_q == DONE;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      type_q <= '0; mode_q <= '0; has_time_q <= 1'b0; eob_last_q <= 1'b0; abort_q <= 1'b0;
      sid_q <= '0; seq_q <= '0; num_samps_q <= '0; samp_cnt_q <= '0; num_pkts_q <= '0;
      cnt_q <= '0; ramp_start_q <= '0; ramp_inc_q <= '0; ts_q <= '0; ts_inc_q <= '0;
      word_q <= '0; gap_q <= '0; gap_cnt_q <= '0;
    end else if (accept) begin
      type_q <= cfg_pkt_type; mode_q <= cfg_mode; has_time_q <= cfg_has_time;
      eob_last_q <= cfg_eob_last; abort_q <= 1'b0; sid_q <= cfg_sid; seq_q <= cfg_seq_start;
      num_samps_q <= cfg_num_samps; samp_cnt_q <= '0; num_pkts_q <= cfg_num_pkts; cnt_q <= '0;
      ramp_start_q <= cfg_ramp_start; ramp_inc_q <= cfg_ramp_inc; ts_q <= cfg_timestamp;
      ts_inc_q <= cfg_ts_inc; word_q <= cfg_ramp_start; gap_q <= cfg_gap; gap_cnt_q <= '0;
    end else begin
      if (abort && in_pkt) abort_q <= 1'b1;
      gap_cnt_q <= state_q == GAP ? gap_cnt_q + GAP_W'(1) : '0;
      if (hs && state_q == DATA) begin
        word_q     <= word_q + ramp_inc_q;
        samp_cnt_q <= samp_cnt_q + 16'd1;
      end
      // Ramp restarts every packet; seqno and timestamp advance once per packet.
      if (end_pkt) begin
        word_q     <= ramp_start_q;
        samp_cnt_q <= '0;
        seq_q      <= seq_q + 12'd1;
        ts_q       <= ts_q + ts_inc_q;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_cvita_pkt_gen.sv
// tb_cvita_pkt_gen: directed bursts with hand-computed CHDR words, gap and stall checks.
module tb_cvita_pkt_gen;
  localparam int CNT_W = 16, GAP_W = 8;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, o_tready = 1'b1;
  logic [1:0] cfg_pkt_type, cfg_mode;
  logic cfg_has_time, cfg_eob_last;
  logic [31:0] cfg_sid;
  logic [11:0] cfg_seq_start;
  logic [15:0] cfg_num_samps;
  logic [CNT_W-1:0] cfg_num_pkts, pkt_count;
  logic [63:0] cfg_ramp_start, cfg_ramp_inc, cfg_timestamp, cfg_ts_inc, o_tdata;
  logic [GAP_W-1:0] cfg_gap;
  logic o_tlast, o_tvalid, busy, done;

  cvita_pkt_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_pkt_type(cfg_pkt_type), .cfg_has_time(cfg_has_time), .cfg_eob_last(cfg_eob_last),
    .cfg_sid(cfg_sid), .cfg_seq_start(cfg_seq_start), .cfg_num_samps(cfg_num_samps),
    .cfg_num_pkts(cfg_num_pkts), .cfg_mode(cfg_mode), .cfg_ramp_start(cfg_ramp_start),
    .cfg_ramp_inc(cfg_ramp_inc), .cfg_timestamp(cfg_timestamp), .cfg_ts_inc(cfg_ts_inc),
    .cfg_gap(cfg_gap), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .busy(busy), .done(done), .pkt_count(pkt_count));

  always #5 clk = ~clk;

  int errs = 0, checks = 0, done_cnt = 0, idle = 0;
  bit in_gap = 0, rnd = 0, prev_stall = 0;
  logic [64:0] prev_w;
  logic [64:0] got_q[$], exp_q[$];
  int gaps[$];

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_stall) chk("stall_hold", {o_tlast, o_tdata}, prev_w);
    prev_stall = o_tvalid && !o_tready;
    prev_w = {o_tlast, o_tdata};
    if (o_tvalid) begin
      if (in_gap) gaps.push_back(idle);
      in_gap = 0;
      idle = 0;
      if (o_tready) begin
        got_q.push_back({o_tlast, o_tdata});
        in_gap = o_tlast;
      end
    end else if (in_gap) idle++;
  end

  task automatic defaults();
    cfg_pkt_type = 2'd0; cfg_has_time = 1'b0; cfg_eob_last = 1'b0; cfg_sid = 32'h0010_0020;
    cfg_seq_start = 12'd0; cfg_num_samps = 16'd4; cfg_num_pkts = 16'd2; cfg_mode = 2'd0;
    cfg_ramp_start = 64'h10; cfg_ramp_inc = 64'h1; cfg_timestamp = 64'h0; cfg_ts_inc = 64'h0;
    cfg_gap = 8'd0;
    got_q.delete(); exp_q.delete(); gaps.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_gap = 0;
    idle = 0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk({tag, "_done"}, 65'(done_cnt - d0), 65'd1);
  endtask

  task automatic add_pkt(input logic [63:0] h, input bit ht, input logic [63:0] ts,
                         input int ns, input logic [63:0] base, input logic [63:0] inc);
    exp_q.push_back({1'(ns == 0 && !ht), h});
    if (ht) exp_q.push_back({1'(ns == 0), ts});
    for (int k = 0; k < ns; k++) exp_q.push_back({1'(k == ns - 1), base + 64'(k) * inc});
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_nwords"}, 65'(got_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int d0;
    defaults();
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 65'(o_tvalid), 65'd0);
    chk("rst_tlast", 65'(o_tlast), 65'd0);
    chk("rst_tdata", 65'(o_tdata), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_done", 65'(done), 65'd0);
    chk("rst_pkt_count", 65'(pkt_count), 65'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("idle_abort_busy", 65'(busy), 65'd0);

    // T1: two 4-sample data packets
    defaults();
    d0 = done_cnt;
    pulse_start();
    chk("t1_first_valid", 65'(o_tvalid), 65'd1);
    chk("t1_busy", 65'(busy), 65'd1);
    wait_done("t1", d0);
    add_pkt(64'h0000_0028_0010_0020, 0, 0, 4, 64'h10, 64'h1);
    add_pkt(64'h0001_0028_0010_0020, 0, 0, 4, 64'h10, 64'h1);
    cmp("t1");
    chk("t1_pkt_count", 65'(pkt_count), 65'd2);
    chk("t1_nogap", 65'(gaps.size() == 1 && gaps[0] == 0), 65'd1);
    chk("t1_idle_busy", 65'(busy), 65'd0);

    // T2: timestamps, eob on last, start while busy ignored
    defaults();
    cfg_has_time = 1'b1; cfg_timestamp = 64'h1000; cfg_ts_inc = 64'h100;
    cfg_num_pkts = 16'd3; cfg_eob_last = 1'b1;
    d0 = done_cnt;
    pulse_start();
    chk("t2_count_clear", 65'(pkt_count), 65'd0);
    cfg_seq_start = 12'd7;
    cfg_num_samps = 16'd9;
    repeat (3) @(posedge clk);
    pulse_start();
    wait_done("t2", d0);
    add_pkt(64'h2000_0030_0010_0020, 1, 64'h1000, 4, 64'h10, 64'h1);
    add_pkt(64'h2001_0030_0010_0020, 1, 64'h1100, 4, 64'h10, 64'h1);
    add_pkt(64'h3002_0030_0010_0020, 1, 64'h1200, 4, 64'h10, 64'h1);
    cmp("t2");
    chk("t2_pkt_count", 65'(pkt_count), 65'd3);

    // T3: T1 under random backpressure
    defaults();
    rnd = 1;
    d0 = done_cnt;
    pulse_start();
    wait_done("t3", d0);
    rnd = 0;
    add_pkt(64'h0000_0028_0010_0020, 0, 0, 4, 64'h10, 64'h1);
    add_pkt(64'h0001_0028_0010_0020, 0, 0, 4, 64'h10, 64'h1);
    cmp("t3");
    chk("t3_pkt_count", 65'(pkt_count), 65'd2);

    // T4: seqno wrap
    defaults();
    cfg_seq_start = 12'd4094; cfg_num_pkts = 16'd3; cfg_num_samps = 16'd1;
    d0 = done_cnt;
    pulse_start();
    wait_done("t4", d0);
    add_pkt(64'h0FFE_0010_0010_0020, 0, 0, 1, 64'h10, 64'h1);
    add_pkt(64'h0FFF_0010_0010_0020, 0, 0, 1, 64'h10, 64'h1);
    add_pkt(64'h0000_0010_0010_0020, 0, 0, 1, 64'h10, 64'h1);
    cmp("t4");

    // T5: continuous mode, abort during packet 5 payload
    defaults();
    cfg_num_pkts = 16'd0; cfg_eob_last = 1'b1;
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 500 && got_q.size() < 22; i++) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done("t5", d0);
    for (int p = 0; p < 5; p++)
      add_pkt({16'(p) | 16'h0000, 48'h0028_0010_0020}, 0, 0, 4, 64'h10, 64'h1);
    cmp("t5");
    chk("t5_pkt_count", 65'(pkt_count), 65'd5);
    chk("t5_tvalid", 65'(o_tvalid), 65'd0);

    // T6: header-only packets with 3-cycle gaps
    defaults();
    cfg_num_samps = 16'd0; cfg_gap = 8'd3; cfg_num_pkts = 16'd3;
    d0 = done_cnt;
    pulse_start();
    wait_done("t6", d0);
    add_pkt(64'h0000_0008_0010_0020, 0, 0, 0, 0, 0);
    add_pkt(64'h0001_0008_0010_0020, 0, 0, 0, 0, 0);
    add_pkt(64'h0002_0008_0010_0020, 0, 0, 0, 0, 0);
    cmp("t6");
    chk("t6_ngaps", 65'(gaps.size()), 65'd2);
    for (int i = 0; i < gaps.size(); i++) chk($sformatf("t6_gap%0d", i), 65'(gaps[i]), 65'd3);

    // Mode 1: LFSR when enabled, otherwise ramp
    defaults();
    cfg_mode = 2'd1; cfg_num_samps = 16'd3;
`ifdef CVITA_PKT_GEN_LFSR_EN
    cfg_ramp_start = 64'h0;
`endif
    d0 = done_cnt;
    pulse_start();
    wait_done("m1", d0);
`ifdef CVITA_PKT_GEN_LFSR_EN
    exp_q.push_back({1'b0, 64'h0000_0020_0010_0020});
    exp_q.push_back({1'b0, 64'h0000_0000_0000_0001});
    exp_q.push_back({1'b0, 64'hD800_0000_0000_0000});
    exp_q.push_back({1'b1, 64'h6C00_0000_0000_0000});
    exp_q.push_back({1'b0, 64'h0001_0020_0010_0020});
    exp_q.push_back({1'b0, 64'h3600_0000_0000_0000});
    exp_q.push_back({1'b0, 64'h1B00_0000_0000_0000});
    exp_q.push_back({1'b1, 64'h0D80_0000_0000_0000});
`else
    add_pkt(64'h0000_0020_0010_0020, 0, 0, 3, 64'h10, 64'h1);
    add_pkt(64'h0001_0020_0010_0020, 0, 0, 3, 64'h10, 64'h1);
`endif
    cmp("m1");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
